// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
//   fetch_state_e    : fetch FSM state encoding (S_REQ, S_WAIT, S_HOLD)
//   IF_ID_t          : IF/ID pipeline register {pc, instr}
//   NOP_INSTR        : ADDI x0,x0,0
//   RESET_PC_DEFAULT : default PC after reset
package if_fetch_stage_pkg;

  typedef logic [1:0] fetch_state_e;
  localparam fetch_state_e S_REQ  = 2'd0;
  localparam fetch_state_e S_WAIT = 2'd1;
  localparam fetch_state_e S_HOLD = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } IF_ID_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and fills the IF/ID register for decode.
// Honours stall from the hazard unit and redirect (taken branch/jump) from EX.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   stall_i                  hold IF/ID, do not load a new instruction
//   redirect_i/redirect_pc_i control transfer taken, target PC
//   imem_req_o/imem_addr_o   fetch request and byte address (= PC)
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    response and instruction word
//   if_id_o/if_id_valid_o    IF_ID_t {pc, instr} and its valid flag
//
// Build option: define IF_NOP_ON_FLUSH_EN to load an explicit NOP
// {target, ADDI x0,x0,0} with valid=1 on redirect instead of a bubble.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [63:0] if_id_o,
  output logic        if_id_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic [31:0]  buf_q, buf_d;
  IF_ID_t       if_id_q, if_id_d;
  logic         valid_q, valid_d;

  logic         load;
  logic [31:0]  load_instr;
  logic [31:0]  redirect_target;

  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    buf_d      = buf_q;
    load       = 1'b0;
    load_instr = buf_q;

    if (redirect_i) begin
      pc_d = redirect_target;
      unique case (state_q)
        S_REQ: begin
          // A granted request is now in flight for the stale PC.
          if (imem_gnt_i) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (!stall_i) begin
              load       = 1'b1;
              load_instr = imem_rdata_i;
              state_d    = S_REQ;
            end else begin
              buf_d   = imem_rdata_i;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            load       = 1'b1;
            load_instr = buf_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
      if (load) pc_d = pc_q + PC_INC;
    end
  end

  // IF/ID register: redirect flushes, stall holds, otherwise load or bubble.
  always_comb begin
    if_id_d = if_id_q;
    valid_d = valid_q;
    if (redirect_i) begin
`ifdef IF_NOP_ON_FLUSH_EN
      if_id_d = '{pc: redirect_target, instr: NOP_INSTR};
      valid_d = 1'b1;
`else
      valid_d = 1'b0;
`endif
    end else if (!stall_i) begin
      valid_d = load;
      if (load) if_id_d = '{pc: pc_q, instr: load_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      buf_q     <= '0;
      if_id_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
      if_id_q   <= if_id_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req_o    = (state_q == S_REQ) && !rst;
  assign imem_addr_o   = pc_q;
  assign if_id_o       = if_id_q;
  assign if_id_valid_o = valid_q;

  // Only one request may be outstanding; a response outside S_WAIT is ignored.
  rvalid_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [63:0] if_id_o;
  logic        if_id_valid_o;

  int n_checks = 0;
  int n_bad    = 0;

`ifdef IF_NOP_ON_FLUSH_EN
  localparam bit NopEn = 1'b1;
`else
  localparam bit NopEn = 1'b0;
`endif

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_o       (if_id_o),
    .if_id_valid_o (if_id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

    // Reset
    step();
    check_eq("rst_req", 64'(imem_req_o), 64'd0);
    check_eq("rst_valid", 64'(if_id_valid_o), 64'd0);
    check_eq("rst_ifid", if_id_o, 64'h0);
    check_eq("rst_addr", 64'(imem_addr_o), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("req_after_rst", 64'(imem_req_o), 64'd1);

    // Sequential fetch: 0x0 then 0x4
    imem_gnt_i = 1'b1; step();
    check_eq("wait_req", 64'(imem_req_o), 64'd0);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0093; step();
    imem_rvalid_i = 1'b0;
    check_eq("seq0_ifid", if_id_o, {32'h0, 32'h00A0_0093});
    check_eq("seq0_valid", 64'(if_id_valid_o), 64'd1);
    check_eq("seq0_addr", 64'(imem_addr_o), 64'h4);
    imem_gnt_i = 1'b1; step();
    check_eq("bubble_valid", 64'(if_id_valid_o), 64'd0);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00B0_0113; step();
    imem_rvalid_i = 1'b0;
    check_eq("seq1_ifid", if_id_o, {32'h4, 32'h00B0_0113});
    check_eq("seq1_valid", 64'(if_id_valid_o), 64'd1);
    check_eq("seq1_addr", 64'(imem_addr_o), 64'h8);

    // Stall: response captured in buffer, IF/ID held through three stall cycles
    stall_i = 1'b1; imem_gnt_i = 1'b1; step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00C0_0193; step();
    imem_rvalid_i = 1'b0; step(); step();
    check_eq("hold_req", 64'(imem_req_o), 64'd0);
    check_eq("hold_ifid", if_id_o, {32'h4, 32'h00B0_0113});
    check_eq("hold_valid", 64'(if_id_valid_o), 64'd1);
    check_eq("hold_addr", 64'(imem_addr_o), 64'h8);
    stall_i = 1'b0; step();
    check_eq("release_ifid", if_id_o, {32'h8, 32'h00C0_0193});
    check_eq("release_valid", 64'(if_id_valid_o), 64'd1);
    check_eq("release_addr", 64'(imem_addr_o), 64'hC);

    // Redirect while waiting: late word dropped, refetch from 0x100
    imem_gnt_i = 1'b1; step();
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100; step();
    redirect_i = 1'b0;
    check_eq("redir_valid", 64'(if_id_valid_o), 64'(NopEn));
    check_eq("redir_addr", 64'(imem_addr_o), 64'h100);
    check_eq("redir_req", 64'(imem_req_o), 64'd0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111; step();
    imem_rvalid_i = 1'b0;
    check_eq("drop_valid", 64'(if_id_valid_o), 64'd0);
    check_eq("drop_ifid", if_id_o,
             NopEn ? {32'h100, 32'h0000_0013} : {32'h8, 32'h00C0_0193});
    check_eq("drop_req", 64'(imem_req_o), 64'd1);
    check_eq("drop_addr", 64'(imem_addr_o), 64'h100);
    imem_gnt_i = 1'b1; step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00D0_0213; step();
    imem_rvalid_i = 1'b0;
    check_eq("tgt_ifid", if_id_o, {32'h100, 32'h00D0_0213});
    check_eq("tgt_valid", 64'(if_id_valid_o), 64'd1);

    // Redirect and stall together: flush wins; low target bits forced to 00
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203; step();
    stall_i = 1'b0; redirect_i = 1'b0;
    check_eq("flush_stall_valid", 64'(if_id_valid_o), 64'(NopEn));
    check_eq("flush_stall_addr", 64'(imem_addr_o), 64'h200);
    imem_gnt_i = 1'b1; step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00E0_0293; step();
    imem_rvalid_i = 1'b0;
    check_eq("resume_ifid", if_id_o, {32'h200, 32'h00E0_0293});
    check_eq("resume_addr", 64'(imem_addr_o), 64'h204);

    // PC wrap at top of address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; step();
    redirect_i = 1'b0;
    check_eq("wrap_pre_addr", 64'(imem_addr_o), 64'hFFFF_FFFC);
    imem_gnt_i = 1'b1; step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00F0_0313; step();
    imem_rvalid_i = 1'b0;
    check_eq("wrap_ifid", if_id_o, {32'hFFFF_FFFC, 32'h00F0_0313});
    check_eq("wrap_addr", 64'(imem_addr_o), 64'h0);

    // Redirect to 0x40: explicit NOP when the option is built in, else bubble
    redirect_i = 1'b1; redirect_pc_i = 32'h40; step();
    redirect_i = 1'b0;
    check_eq("nop_valid", 64'(if_id_valid_o), 64'(NopEn));
    check_eq("nop_ifid", if_id_o,
             NopEn ? {32'h40, 32'h0000_0013} : {32'hFFFF_FFFC, 32'h00F0_0313});
    check_eq("nop_addr", 64'(imem_addr_o), 64'h40);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32 pipeline. Owns the PC and issues one-outstanding requests to instruction memory. Buffers returned words and drives the IF/ID pipeline register (IF_ID_t) consumed by decode. Honours stall from the hazard unit and redirect (taken BEQ / JAL) from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment for sequential fetch.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall_i  input  1  hazard unit: hold IF/ID contents, no new load.
redirect_i  input  1  EX: control transfer taken; flush and refetch.
redirect_pc_i  input  32  target PC, valid with redirect_i.
imem_req_o  output  1  fetch request valid.
imem_addr_o  output  32  fetch byte address, always equal to PC.
imem_gnt_i  input  1  memory accepts request this cycle (req & gnt = handshake).
imem_rvalid_i  input  1  response valid; at most one per granted request, at least 1 cycle after gnt.
imem_rdata_i  input  32  instruction word, valid with rvalid.
if_id_o  output  64  IF_ID_t {PC, instr32} for decode.
if_id_valid_o  output  1  if_id_o holds a real instruction.

Behaviour:
- Reset (rst=1 at edge): PC<=RESET_PC, state<=S_REQ, discard<=0, if_id_o<=0, if_id_valid_o<=0, buffer cleared.
- imem_req_o is registered-state decoded: 1 only in S_REQ, 0 during the reset cycle.
- States:
  - S_REQ: req=1, addr=PC. On gnt, go to S_WAIT.
  - S_WAIT: await rvalid. On rvalid with discard=1: drop word, discard<=0, go to S_REQ. On rvalid with stall_i=0: if_id_o<={PC,rdata}, valid<=1, PC<=PC+PC_INC, go to S_REQ. On rvalid with stall_i=1: capture word in buffer, go to S_HOLD.
  - S_HOLD: on the first cycle with stall_i=0, load buffer into IF/ID, valid<=1, PC<=PC+PC_INC, go to S_REQ.
- IF/ID update rule: stall_i=1 leaves if_id_o and valid unchanged. stall_i=0 with no instruction to load gives valid<=0 (bubble). if_id_o data bits are then don't-care but held.
- Redirect (highest priority, beats stall): PC<=redirect_pc_i and if_id_valid_o<=0 that cycle.
  - In S_REQ without gnt: stay in S_REQ; the new address is presented next cycle.
  - In S_REQ with gnt, or in S_WAIT without rvalid: discard<=1, go to S_WAIT.
  - In S_WAIT with rvalid, or in S_HOLD: drop the word, go to S_REQ.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. redirect_pc_i[1:0] is ignored and forced to 00.
- Throughput: best case 1 instruction per 2 cycles (gnt cycle plus rvalid cycle). Latency from gnt to if_id_valid_o is 1 cycle after rvalid.
- Only one request is ever outstanding. rvalid arriving in S_REQ/S_HOLD is a protocol error; assert in simulation and ignore.

Optional Feature:
IF_NOP_ON_FLUSH_EN:
- Defined: wherever the rules above force if_id_valid_o<=0 due to redirect, instead load if_id_o<={redirect_pc_i, 32'h0000_0013} (ADDI x0,x0,0) with valid=1, so decode sees an explicit NOP.
- Undefined: valid<=0 as specified above.

Decomposition:
- Shared package gets: fetch_state_e enum {S_REQ, S_WAIT, S_HOLD}; constant NOP_INSTR = 32'h0000_0013; constant RESET_PC_DEFAULT.
- IF_ID_t is reused unchanged.
- No sub-module required. PC-next mux is inline.

Test Plan:
- Reset, then gnt every cycle and rvalid 1 cycle later with 0x00A00093/0x00B00113 -> if_id_o={0x0,0x00A00093}, then {0x4,0x00B00113}; imem_addr_o sequence 0,4,8.
- rvalid with stall_i=1 held 3 cycles -> state S_HOLD, IF/ID unchanged; on release, IF/ID={PC,word} next edge, PC+=4.
- redirect_i=1, redirect_pc_i=0x100 while in S_WAIT -> late rvalid word dropped, valid=0, next request addr=0x100.
- redirect and stall_i same cycle -> valid<=0 (flush wins); fetch resumes at target.
- PC=0xFFFFFFFC fetched -> next imem_addr_o=0x0.
- With IF_NOP_ON_FLUSH_EN, redirect to 0x40 -> if_id_o={0x40,0x00000013}, valid=1.
